// File: rtl/datapath.sv
// Datapath: 16x16 register file, 256x16 synchronous-read data memory,
// eight-function ALU and registered {C, N, Z} status flags.
module datapath (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  D_Addr,
  input  logic        D_Wr,
  input  logic        RF_s,
  input  logic        RF_W_en,
  input  logic [3:0]  RF_W_Addr,
  input  logic [3:0]  RF_Ra_Addr,
  input  logic [3:0]  RF_Rb_Addr,
  input  logic [2:0]  ALU_s0,
  output logic [15:0] Ra_Data,
  output logic [15:0] Rb_Data,
  output logic [15:0] ALU_Out,
  output logic [15:0] W_Data,
  output logic [2:0]  Flags
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_PASS = 3'b010,
    OP_OR   = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_INC  = 3'b110,
    OP_ZERO = 3'b111
  } alu_op_e;

  logic [15:0] rf  [16];
  logic [15:0] mem [256];
  logic [15:0] rd_data;
  logic [16:0] alu_sum;
  logic        alu_c;

  // Combinational read ports; writes land at the edge, so same-cycle reads see the old value.
  assign Ra_Data = rf[RF_Ra_Addr];
  assign Rb_Data = rf[RF_Rb_Addr];

  always_comb begin
    alu_sum = '0;
    alu_c   = 1'b0;
    case (alu_op_e'(ALU_s0))
      OP_ADD: begin
        alu_sum = {1'b0, Ra_Data} + {1'b0, Rb_Data};
        alu_c   = alu_sum[16];
      end
      OP_SUB: begin
        // Bit 16 of the zero-extended difference is set exactly when A < B unsigned.
        alu_sum = {1'b0, Ra_Data} - {1'b0, Rb_Data};
        alu_c   = alu_sum[16];
      end
      OP_PASS: alu_sum = {1'b0, Ra_Data};
      OP_OR:   alu_sum = {1'b0, Ra_Data | Rb_Data};
      OP_AND:  alu_sum = {1'b0, Ra_Data & Rb_Data};
      OP_XOR:  alu_sum = {1'b0, Ra_Data ^ Rb_Data};
      OP_INC: begin
        alu_sum = {1'b0, Ra_Data} + 17'd1;
        alu_c   = alu_sum[16];
      end
      OP_ZERO: alu_sum = '0;
      default: alu_sum = '0;
    endcase
  end

  assign ALU_Out = alu_sum[15:0];
  assign W_Data  = RF_s ? rd_data : ALU_Out;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 16; i++) rf[i] <= '0;
    end else if (RF_W_en) begin
      rf[RF_W_Addr] <= W_Data;
    end
  end

  // Memory contents survive reset; only the read-data register is cleared.
  always_ff @(posedge Clk) begin
    if (!Reset && D_Wr) mem[D_Addr] <= Ra_Data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) rd_data <= '0;
    else       rd_data <= mem[D_Addr];
  end

  always_ff @(posedge Clk) begin
    if (Reset)                    Flags <= '0;
    else if (RF_W_en && !RF_s)    Flags <= {alu_c, ALU_Out[15], ALU_Out == 16'h0000};
  end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: a behavioural model predicts every cycle's
// outputs into a queue that a negedge monitor drains and compares.
module tb_datapath;

  logic        Clk;
  logic        Reset;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_Addr;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;
  logic [15:0] Ra_Data;
  logic [15:0] Rb_Data;
  logic [15:0] ALU_Out;
  logic [15:0] W_Data;
  logic [2:0]  Flags;

  datapath dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .D_Addr     (D_Addr),
    .D_Wr       (D_Wr),
    .RF_s       (RF_s),
    .RF_W_en    (RF_W_en),
    .RF_W_Addr  (RF_W_Addr),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .ALU_s0     (ALU_s0),
    .Ra_Data    (Ra_Data),
    .Rb_Data    (Rb_Data),
    .ALU_Out    (ALU_Out),
    .W_Data     (W_Data),
    .Flags      (Flags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // mask bits: 0 Ra, 1 Rb, 2 ALU, 3 W_Data, 4 Flags
  typedef struct {
    string       name;
    logic [4:0]  mask;
    logic [15:0] ra, rb, alu, wd;
    logic [2:0]  fl;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  int unsigned rf_m  [16];
  int unsigned mem_m [256];
  int unsigned rd_m;
  bit [2:0]    flags_m;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.mask[0]) chk({e.name, ".Ra_Data"}, Ra_Data, e.ra);
      if (e.mask[1]) chk({e.name, ".Rb_Data"}, Rb_Data, e.rb);
      if (e.mask[2]) chk({e.name, ".ALU_Out"}, ALU_Out, e.alu);
      if (e.mask[3]) chk({e.name, ".W_Data"},  W_Data,  e.wd);
      if (e.mask[4]) chk({e.name, ".Flags"},   {13'd0, Flags}, {13'd0, e.fl});
    end
  end

  function automatic void ref_alu(input int unsigned a, input int unsigned b, input int unsigned op,
                                  output int unsigned res, output bit c);
    int unsigned t;
    c = 1'b0;
    case (op)
      0: begin t = a + b; res = t % 65536; c = (t > 65535); end
      1: begin res = (a + 65536 - b) % 65536; c = (a < b); end
      2: res = a;
      3: res = a | b;
      4: res = a & b;
      5: res = a ^ b;
      6: begin t = a + 1; res = t % 65536; c = (t > 65535); end
      default: res = 0;
    endcase
  endfunction

  function automatic void push_const(input string name, input logic [4:0] mask,
                                     input logic [15:0] ra, input logic [15:0] alu,
                                     input logic [15:0] wd, input logic [2:0] fl);
    exp_t e;
    e.name = name; e.mask = mask; e.ra = ra; e.rb = '0; e.alu = alu; e.wd = wd; e.fl = fl;
    q.push_back(e);
  endfunction

  // Apply one cycle of inputs, predict the outputs, then advance the model past the edge.
  task automatic drive(input logic [2:0] op, input logic [3:0] wa, input logic [3:0] raa,
                       input logic [3:0] rba, input logic wen, input logic rfs,
                       input logic [7:0] da, input logic dwr, input logic rst);
    exp_t e;
    int unsigned ra, rb, alu, wd, rd_nxt;
    bit c;
    Reset = rst; ALU_s0 = op; RF_W_Addr = wa; RF_Ra_Addr = raa; RF_Rb_Addr = rba;
    RF_W_en = wen; RF_s = rfs; D_Addr = da; D_Wr = dwr;
    ra = rf_m[raa];
    rb = rf_m[rba];
    ref_alu(ra, rb, int'(op), alu, c);
    wd = rfs ? rd_m : alu;
    e.name = "model"; e.mask = 5'h1F;
    e.ra = 16'(ra); e.rb = 16'(rb); e.alu = 16'(alu); e.wd = 16'(wd); e.fl = flags_m;
    q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_m[i] = 0;
      flags_m = '0;
      rd_m = 0;
    end else begin
      rd_nxt = mem_m[da];
      if (dwr) mem_m[da] = ra;
      if (wen) rf_m[wa] = wd;
      if (wen && !rfs) flags_m = {c, alu >= 32768, alu == 0};
      rd_m = rd_nxt;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cyc(input logic [2:0] op, input logic [3:0] wa, input logic [3:0] raa,
                     input logic [3:0] rba, input logic wen, input logic rfs,
                     input logic [7:0] da, input logic dwr, input logic rst);
    drive(op, wa, raa, rba, wen, rfs, da, dwr, rst);
    step();
  endtask

  // Build a constant by repeated doubling (A+A) and increment.
  task automatic load_const(input logic [3:0] r, input logic [15:0] val);
    cyc(3'b111, r, 4'd0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      cyc(3'b000, r, r, r, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      if (val[i]) cyc(3'b110, r, r, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_m[i] = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = 0;
    rd_m = 0; flags_m = '0;
    Reset = 1'b1; ALU_s0 = '0; RF_W_Addr = '0; RF_Ra_Addr = '0; RF_Rb_Addr = '0;
    RF_W_en = 1'b0; RF_s = 1'b0; D_Addr = '0; D_Wr = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Post-reset outputs: INC on zero gives 1, W_Data from cleared read register.
    drive(3'b110, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    push_const("post_reset", 5'b11101, 16'h0000, 16'h0001, 16'h0000, 3'b000);
    step();

    // R1 incremented three times from R0.
    cyc(3'b110, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc(3'b110, 4'd1, 4'd1, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc(3'b110, 4'd1, 4'd1, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(3'b010, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    push_const("r1_inc3", 5'b10001, 16'h0003, 16'h0003, 16'h0003, 3'b000);
    step();

    // Fill memory: mem[i] = 3 + i, R1 counting alongside.
    for (int i = 0; i < 256; i++)
      cyc(3'b110, 4'd1, 4'd1, 4'd0, 1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
    cyc(3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // FFFF + 1 wraps to zero with carry.
    load_const(4'd2, 16'hFFFF);
    load_const(4'd3, 16'h0001);
    drive(3'b000, 4'd4, 4'd2, 4'd3, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    push_const("add_wrap", 5'b00100, 16'h0000, 16'h0000, 16'h0000, 3'b000);
    step();
    drive(3'b010, 4'd0, 4'd4, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    push_const("add_wrap_flags", 5'b10001, 16'h0000, 16'h0000, 16'h0000, 3'b101);
    step();

    // 3 - 5 borrows and goes negative.
    load_const(4'd9, 16'h0003);
    load_const(4'd10, 16'h0005);
    drive(3'b001, 4'd11, 4'd9, 4'd10, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    push_const("sub_borrow", 5'b00100, 16'h0000, 16'hFFFE, 16'h0000, 3'b000);
    step();
    drive(3'b010, 4'd0, 4'd11, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    push_const("sub_borrow_flags", 5'b10000, 16'h0000, 16'h0000, 16'h0000, 3'b110);
    step();

    // Store R5 to 0x80, read-first shows old data, then LOAD into R6.
    load_const(4'd5, 16'h1234);
    cyc(3'b010, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
    drive(3'b010, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    push_const("mem_read_first", 5'b01000, 16'h0000, 16'h0000, 16'h0083, 3'b000);
    step();
    drive(3'b010, 4'd6, 4'd5, 4'd0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
    push_const("load_wdata", 5'b01000, 16'h0000, 16'h0000, 16'h1234, 3'b000);
    step();
    drive(3'b010, 4'd0, 4'd6, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push_const("load_r6", 5'b00001, 16'h1234, 16'h0000, 16'h0000, 3'b000);
    step();

    // Last memory word.
    cyc(3'b010, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    cyc(3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    drive(3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    push_const("mem_ff", 5'b01000, 16'h0000, 16'h0000, 16'h1234, 3'b000);
    step();

    // Same-cycle read/write of R8: old value before the edge, new after.
    load_const(4'd8, 16'h00AA);
    load_const(4'd12, 16'h00FF);
    drive(3'b101, 4'd8, 4'd8, 4'd12, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    push_const("rf_old", 5'b00001, 16'h00AA, 16'h0000, 16'h0000, 3'b000);
    step();
    drive(3'b010, 4'd0, 4'd8, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    push_const("rf_new", 5'b00001, 16'h0055, 16'h0000, 16'h0000, 3'b000);
    step();

    // Reset beats a register write and a memory write in the same cycle.
    cyc(3'b010, 4'd7, 4'd8, 4'd0, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1);
    drive(3'b010, 4'd0, 4'd7, 4'd0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    push_const("reset_r7", 5'b11001, 16'h0000, 16'h0000, 16'h0000, 3'b000);
    step();
    drive(3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
    push_const("mem_kept_80", 5'b01000, 16'h0000, 16'h0000, 16'h1234, 3'b000);
    step();
    drive(3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    push_const("mem_kept_81", 5'b01000, 16'h0000, 16'h0000, 16'h0084, 3'b000);
    step();

    // LOAD interrupted by reset leaves the destination at zero.
    load_const(4'd13, 16'h0BEE);
    cyc(3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0);
    cyc(3'b010, 4'd13, 4'd0, 4'd0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
    drive(3'b010, 4'd0, 4'd13, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push_const("load_reset", 5'b00001, 16'h0000, 16'h0000, 16'h0000, 3'b000);
    step();

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
          8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 59) == 0));
    end

    @(negedge Clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clk  in  1  system clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 D_Addr  in  8  data-memory word address from control unit.
REQ-004 D_Wr  in  1  data-memory write enable.
REQ-005 RF_s  in  1  register-file write-data select: 0 = ALU result, 1 = data-memory read data.
REQ-006 RF_W_en  in  1  register-file write enable.
REQ-007 RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr  in  4 each  write, read-A and read-B register addresses.
REQ-008 ALU_s0  in  3  ALU operation select.
REQ-009 Ra_Data, Rb_Data  out  16 each  current register-file read-port values.
REQ-010 ALU_Out  out  16  combinational ALU result.
REQ-011 W_Data  out  16  value presented to the register-file write port.
REQ-012 Flags  out  3  registered status {C, N, Z}.

Function
REQ-013 Register file SHALL be 16 x 16 bits, with two combinational read ports and one write port clocked on the rising edge.
REQ-014 A read of the address being written in the same cycle SHALL return the old value; there SHALL be no bypass.
REQ-015 Data memory SHALL be 256 x 16 bits, single port, with a synchronous read: the read-data register captures mem[D_Addr] every edge, giving 1-cycle latency.
REQ-016 When D_Wr=1, mem[D_Addr] SHALL be loaded with Ra_Data at the edge.
REQ-017 A memory read of the address being written in the same cycle SHALL return the old contents (read-first).
REQ-018 ALU A = Ra_Data, B = Rb_Data. ALU_s0 encoding: 000 A+B; 001 A-B; 010 A; 011 A|B; 100 A&B; 101 A^B; 110 A+1; 111 16'h0000.
REQ-019 ALU arithmetic SHALL be 16-bit modulo 2^16.
REQ-020 The carry bit SHALL be the 17th bit for 000 and 110, and the borrow (A<B unsigned) for 001; for all other operations it SHALL be 0.
REQ-021 W_Data SHALL equal RF_s ? memory read-data register : ALU_Out.
REQ-022 When RF_W_en=1, RF[RF_W_Addr] SHALL be loaded with W_Data at the edge.
REQ-023 LOAD timing: D_Addr is presented in cycle N with RF_s=0 and RF_W_en=0; RF_s=1 and RF_W_en=1 are asserted in cycle N+1; the register holds the value at edge N+2.
REQ-024 Flags SHALL update at the edge only when RF_W_en=1 and RF_s=0: Z = (ALU_Out==0), N = ALU_Out[15], C per REQ-020. Otherwise Flags SHALL hold.
REQ-025 D_Wr and RF_W_en asserted in the same cycle SHALL both take effect. Memory data is the pre-edge Ra_Data.
REQ-026 Address ranges SHALL be full-width with no out-of-range case; D_Addr 8'hFF is a valid last word with no wrap side effects.
REQ-027 No output SHALL depend combinationally on Reset.

Reset
REQ-028 With Reset=1 at an edge, all 16 registers SHALL clear to 16'h0000.
REQ-029 With Reset=1 at an edge, Flags SHALL clear to 3'b000 and the memory read-data register SHALL clear to 16'h0000.
REQ-030 During reset, data-memory contents SHALL be retained; D_Wr SHALL be ignored.
REQ-031 Reset SHALL have priority over RF_W_en and D_Wr in the same cycle.
REQ-032 A LOAD interrupted by reset between cycle N and N+1 SHALL leave the destination register at 0.
REQ-033 After reset: Ra_Data = Rb_Data = 0, ALU_Out = per ALU_s0 on zeros, W_Data = 0 when RF_s=1.

Verification
REQ-034 Reset, then ALU_s0=110 with Ra=0, W=1, RF_W_en=1 for 3 cycles (Ra=W=1 after the first) -> R1=16'h0003, Flags=000.
REQ-035 R2=16'hFFFF, R3=16'h0001, ALU_s0=000, W=4 -> R4=16'h0000, Flags Z=1, C=1, N=0.
REQ-036 R5=16'h1234, D_Addr=8'h80, D_Wr=1 -> one cycle later, read of 8'h80 -> R6=16'h1234 after LOAD per REQ-023. The read issued in the write cycle returns the old contents.
REQ-037 ALU_s0=001 with A=16'h0003, B=16'h0005 -> ALU_Out=16'hFFFE, C=1, N=1, Z=0.
REQ-038 Write R7 with RF_W_en=1 and Reset=1 in the same cycle -> R7=0, Flags=000. Memory written before reset is still readable after reset.
REQ-039 Same-cycle read/write of R8, old value 16'h00AA, new value 16'h0055 -> Ra_Data shows 16'h00AA until the edge, then 16'h0055.
